// File: rtl/mpu_mul_seq_if.sv
// Command/result bundle between the MPU command path, the sequential
// matrix-multiply scheduler and the result store.
interface mpu_mul_seq_if #(
    parameter int DIM = 5,
    parameter int W   = 8
);
    logic                 start;
    logic [2:0]           size;
    logic [W*DIM*DIM-1:0] matrix_a;
    logic [W*DIM*DIM-1:0] matrix_b;
    logic [W*DIM*DIM-1:0] result;
    logic                 busy;
    logic                 done;
    logic                 err;

    // Command side: issues requests, consumes the product and status
    modport master (
        output start, size, matrix_a, matrix_b,
        input  result, busy, done, err
    );

    // Scheduler side: accepts requests, produces the product and status
    modport slave (
        input  start, size, matrix_a, matrix_b,
        output result, busy, done, err
    );
endinterface

// File: rtl/mpu_mul_seq.sv
// Sequential scheduler for an NxN (N <= DIM) signed matrix multiply C = A x B.
// One shared MAC produces one product per clock, walking row i, column j and
// inner index k. Arithmetic is modulo 2^W throughout (truncating, wrapping).
module mpu_mul_seq #(
    parameter int DIM = 5,
    parameter int W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    mpu_mul_seq_if.slave       bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [2:0] DIM_L  = 3'(DIM);

    logic [1:0]   state_q, state_d;
    logic [2:0]   i_q, i_d, j_q, j_d, k_q, k_d, n_q;
    logic [W-1:0] acc_q, acc_d;
    logic         busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [W-1:0] a_in_s [DIM][DIM];
    logic [W-1:0] b_in_s [DIM][DIM];
    logic [W-1:0] a_q    [DIM][DIM];
    logic [W-1:0] b_q    [DIM][DIM];
    logic [W-1:0] res_q  [DIM][DIM];

    logic [W-1:0] prod_s, acc_next_s;
    logic [2:0]   nm1_s;
    logic         start_ok_s, start_bad_s, last_i_s, last_j_s, last_k_s;
    logic         load_s, wr_s;

    // Unpack operands and pack the result with the shared elem(r,c) layout
    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            assign a_in_s[r][c] = bus.matrix_a[W*(DIM*r+c) +: W];
            assign b_in_s[r][c] = bus.matrix_b[W*(DIM*r+c) +: W];
            assign bus.result[W*(DIM*r+c) +: W] = res_q[r][c];
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

    // Product is truncated to W bits before accumulation; the sum wraps
    assign prod_s      = a_q[i_q][k_q] * b_q[k_q][j_q];
    assign acc_next_s  = acc_q + prod_s;
    assign nm1_s       = n_q - 3'd1;
    assign last_i_s    = (i_q == nm1_s);
    assign last_j_s    = (j_q == nm1_s);
    assign last_k_s    = (k_q == nm1_s);
    assign start_ok_s  = bus.start && (bus.size != 3'd0) && (bus.size <= DIM_L);
    assign start_bad_s = bus.start && !start_ok_s;

    // Next-state logic for the walk counters, accumulator and status flags
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_s  = 1'b0;
        wr_s    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_s) begin
                    state_d = S_MAC;
                    load_s  = 1'b1;
                    busy_d  = 1'b1;
                    i_d     = 3'd0;
                    j_d     = 3'd0;
                    k_d     = 3'd0;
                    acc_d   = {W{1'b0}};
                end else if (start_bad_s) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                busy_d = 1'b1;
                if (!last_k_s) begin
                    k_d   = k_q + 3'd1;
                    acc_d = acc_next_s;
                end else begin
                    wr_s  = 1'b1;
                    k_d   = 3'd0;
                    acc_d = {W{1'b0}};
                    if (!last_j_s) begin
                        j_d = j_q + 3'd1;
                    end else begin
                        j_d = 3'd0;
                        if (!last_i_s) begin
                            i_d = i_q + 3'd1;
                        end else begin
                            i_d     = 3'd0;
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers: state, counters, accumulator and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= 3'd0;
            j_q     <= 3'd0;
            k_q     <= 3'd0;
            n_q     <= 3'd0;
            acc_q   <= {W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (load_s) begin
                n_q <= bus.size;
            end
        end
    end

    // Operand latch: captured once at acceptance so mid-run changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_q[r][c] <= {W{1'b0}};
                    b_q[r][c] <= {W{1'b0}};
                end
            end
        end else if (load_s) begin
            a_q <= a_in_s;
            b_q <= b_in_s;
        end
    end

    // Result store: cleared on reset or acceptance, one element per row/col pass
    always_ff @(posedge clk) begin
        if (rst || load_s) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    res_q[r][c] <= {W{1'b0}};
                end
            end
        end else if (wr_s) begin
            res_q[i_q][j_q] <= acc_next_s;
        end
    end
endmodule
